// File: rtl/cv32e40p_apu_arbiter_if.sv
// Bundles the core-side APU channels and the shared-FPU channels of the
// APU arbiter. The master modport is the environment (cores + FPU) and the
// slave modport is the arbiter itself.
interface cv32e40p_apu_arbiter_if #(
   parameter int NUM_REQ  = 2,
   parameter int NARGS    = 3,
   parameter int WOP      = 6,
   parameter int NDSFLAGS = 15,
   parameter int NUSFLAGS = 5
);
   // core side
   logic [NUM_REQ-1:0]          apu_req_i;
   logic [NUM_REQ-1:0]          apu_gnt_o;
   logic [NUM_REQ*NARGS*32-1:0] apu_operands_i;
   logic [NUM_REQ*WOP-1:0]      apu_op_i;
   logic [NUM_REQ*NDSFLAGS-1:0] apu_flags_i;
   logic [NUM_REQ-1:0]          apu_rvalid_o;
   logic [31:0]                 apu_result_o;
   logic [NUSFLAGS-1:0]         apu_flags_o;
   // shared unit side
   logic                        fpu_req_o;
   logic                        fpu_gnt_i;
   logic [NARGS*32-1:0]         fpu_operands_o;
   logic [WOP-1:0]              fpu_op_o;
   logic [NDSFLAGS-1:0]         fpu_flags_o;
   logic                        fpu_rvalid_i;
   logic [31:0]                 fpu_result_i;
   logic [NUSFLAGS-1:0]         fpu_flags_i;

   modport master (
      output apu_req_i, apu_operands_i, apu_op_i, apu_flags_i,
             fpu_gnt_i, fpu_rvalid_i, fpu_result_i, fpu_flags_i,
      input  apu_gnt_o, apu_rvalid_o, apu_result_o, apu_flags_o,
             fpu_req_o, fpu_operands_o, fpu_op_o, fpu_flags_o
   );

   modport slave (
      input  apu_req_i, apu_operands_i, apu_op_i, apu_flags_i,
             fpu_gnt_i, fpu_rvalid_i, fpu_result_i, fpu_flags_i,
      output apu_gnt_o, apu_rvalid_o, apu_result_o, apu_flags_o,
             fpu_req_o, fpu_operands_o, fpu_op_o, fpu_flags_o
   );
endinterface

// File: rtl/cv32e40p_apu_arbiter.sv
// Round-robin arbiter sharing one APU/FPU between NUM_REQ cores. Granted
// requester IDs go into an in-order tag FIFO so that each response is routed
// back to the core that issued it.
// Optional macro CV32E40P_APU_ARB_ERR_EN: enables the sticky err_o flag for
// responses arriving with no outstanding tag (otherwise err_o is tied low).
module cv32e40p_apu_arbiter #(
   parameter int NUM_REQ         = 2,
   parameter int NARGS           = 3,
   parameter int WOP             = 6,
   parameter int NDSFLAGS        = 15,
   parameter int NUSFLAGS        = 5,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   cv32e40p_apu_arbiter_if.slave   bus,
   output logic                    err_o
);
   localparam int IDW = $clog2(NUM_REQ);
   localparam int PW  = $clog2(MAX_OUTSTANDING);
   localparam int CW  = PW + 1;

   logic [IDW-1:0]                       rr_ptr_q, rr_ptr_d;
   logic                                 lock_q, lock_d;
   logic [IDW-1:0]                       lock_id_q, lock_id_d;
   logic [MAX_OUTSTANDING-1:0][IDW-1:0]  tag_q;
   logic [PW-1:0]                        wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]                        cnt_q, cnt_d;

   logic [IDW-1:0] sel;
   logic [IDW:0]   idx;
   logic           found;
   logic           full, push, pop;
   logic [IDW-1:0] head;

   assign full = (cnt_q == CW'(MAX_OUTSTANDING));
   assign push = bus.fpu_req_o & bus.fpu_gnt_i;
   assign pop  = bus.fpu_rvalid_i & (cnt_q != '0);
   assign head = tag_q[rd_ptr_q];

   // Pick the requester: locked ID while a request waits, else first
   // asserted request scanning upward from rr_ptr_q with wrap-around.
   always_comb begin
      sel   = rr_ptr_q;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, rr_ptr_q} + (IDW+1)'(k);
         if (idx >= (IDW+1)'(NUM_REQ)) idx = idx - (IDW+1)'(NUM_REQ);
         if (!found && bus.apu_req_i[idx[IDW-1:0]]) begin
            sel   = idx[IDW-1:0];
            found = 1'b1;
         end
      end
      if (lock_q) sel = lock_id_q;
   end

   // Forward the selected core's payload and generate request/grants.
   always_comb begin
      bus.fpu_req_o      = (|bus.apu_req_i) & ~full;
      bus.fpu_operands_o = '0;
      bus.fpu_op_o       = '0;
      bus.fpu_flags_o    = '0;
      bus.apu_gnt_o      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (sel == IDW'(i)) begin
            bus.fpu_operands_o = bus.apu_operands_i[i*NARGS*32 +: NARGS*32];
            bus.fpu_op_o       = bus.apu_op_i[i*WOP +: WOP];
            bus.fpu_flags_o    = bus.apu_flags_i[i*NDSFLAGS +: NDSFLAGS];
            bus.apu_gnt_o[i]   = push;
         end
      end
   end

   // Route a response to the oldest outstanding tag; data is broadcast.
   always_comb begin
      bus.apu_rvalid_o = '0;
      if (pop) bus.apu_rvalid_o[head] = 1'b1;
   end
   assign bus.apu_result_o = bus.fpu_result_i;
   assign bus.apu_flags_o  = bus.fpu_flags_i;

   // Next-state for round-robin pointer, lock and FIFO occupancy.
   always_comb begin
      rr_ptr_d  = rr_ptr_q;
      lock_d    = lock_q;
      lock_id_d = lock_id_q;
      cnt_d     = cnt_q;
      if (push) begin
         rr_ptr_d = (sel == IDW'(NUM_REQ-1)) ? '0 : sel + 1'b1;
         lock_d   = 1'b0;
      end else if (bus.fpu_req_o) begin
         // keep the selection stable until the unit accepts it
         lock_d    = 1'b1;
         lock_id_d = sel;
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Arbitration and tag FIFO state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q  <= '0;
         lock_q    <= 1'b0;
         lock_id_q <= '0;
         tag_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
         cnt_q     <= cnt_d;
         if (push) begin
            tag_q[wr_ptr_q] <= sel;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

`ifdef CV32E40P_APU_ARB_ERR_EN
   logic err_q;

   // Sticky flag: a response came back with nothing outstanding.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                                err_q <= 1'b0;
      else if (bus.fpu_rvalid_i && cnt_q == '0)   err_q <= 1'b1;
   end
   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif
endmodule

// File: doc/cv32e40p_apu_arbiter.md
# cv32e40p_apu_arbiter

Shares one APU/FPU instance between NUM_REQ cv32e40p cores in a PULP cluster configuration. Arbitrates the cores' APU request channels round-robin, forwards the winning operands/op/flags to the shared unit, and records the ID of every granted requester in an in-order tag FIFO. Each response from the unit is routed back to the core that issued the matching request. Sits between the cores' apu_* ports and the shared FPU's request/response channels.

## Interface
- NUM_REQ, 2: number of requesting cores (2..8)
- NARGS, 3: operands per request (32 bits each)
- WOP, 6: op width
- NDSFLAGS, 15: downstream flag width
- NUSFLAGS, 5: upstream flag width
- MAX_OUTSTANDING, 4: tag FIFO depth; power of two, 2..16
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- apu_req_i  in  NUM_REQ  per-core request
- apu_gnt_o  out  NUM_REQ  per-core grant
- apu_operands_i  in  NUM_REQ*NARGS*32  per-core operands, core i at slice i
- apu_op_i  in  NUM_REQ*WOP  per-core op
- apu_flags_i  in  NUM_REQ*NDSFLAGS  per-core flags
- apu_rvalid_o  out  NUM_REQ  per-core response valid
- apu_result_o  out  32  result, broadcast to all cores
- apu_flags_o  out  NUSFLAGS  response flags, broadcast
- fpu_req_o  out  1  request to shared unit
- fpu_gnt_i  in  1  grant from shared unit
- fpu_operands_o  out  NARGS*32  selected operands
- fpu_op_o  out  WOP  selected op
- fpu_flags_o  out  NDSFLAGS  selected flags
- fpu_rvalid_i  in  1  response valid (in order of grants)
- fpu_result_i  in  32  response result
- fpu_flags_i  in  NUSFLAGS  response flags
- err_o  out  1  sticky: response arrived with empty tag FIFO

## Operation
- State: rr_ptr_q (priority start), lock_q/lock_id_q, tag FIFO (wr_ptr, rd_ptr, count 0..MAX_OUTSTANDING), err_q.
- Selection: if lock_q, sel = lock_id_q; else first asserted apu_req_i scanning from rr_ptr_q upward, wrapping mod NUM_REQ.
- full = (count == MAX_OUTSTANDING). fpu_req_o = |apu_req_i & ~full. fpu_operands_o/op/flags = slice of sel.
- apu_gnt_o[sel] = fpu_gnt_i & fpu_req_o; all other grants 0.
- Lock: fpu_req_o high and no fpu_gnt_i -> lock_q=1, lock_id_q=sel; cleared on grant. Selection is stable while a request is pending. Cores must hold request until granted (OBI-style); the lock is not cleared if the core drops its request.
- On grant: push sel into FIFO; rr_ptr_q = (sel+1) mod NUM_REQ.
- On fpu_rvalid_i with count>0: pop head h; apu_rvalid_o[h]=1 in the same cycle; apu_result_o/apu_flags_o = fpu_result_i/fpu_flags_i pass-through.
- On fpu_rvalid_i with count==0: no apu_rvalid_o; err_q set (sticky until reset).
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full: no grant, even if a pop occurs in the same cycle. fpu_req_o is low while full.
- Pointers wrap mod MAX_OUTSTANDING.

## Timing
- Reset: apu_gnt_o=0, apu_rvalid_o=0, fpu_req_o=0 (no requests), err_o=0, rr_ptr_q=0, lock_q=0, count=0, FIFO pointers 0.
- Request path is combinational: apu_req_i to fpu_req_o, and fpu_gnt_i to apu_gnt_o, in 0 cycles.
- Response path is combinational: fpu_rvalid_i to apu_rvalid_o in 0 cycles.
- FIFO, rr_ptr, lock and err update on the rising clk_i edge.
- Reset mid-operation clears all outstanding tags. Responses arriving after reset for pre-reset grants set err_o.
- Single requester back-to-back: one grant per cycle while fpu_gnt_i=1 and not full.

## Configuration
- CV32E40P_APU_ARB_ERR_EN defined: err_q detection as above.
- Not defined: err_o tied to 0 and no err_q flop. An unexpected fpu_rvalid_i is dropped silently.
- Routing behaviour is identical in both builds.

## Test plan
- Fairness: cores 0 and 1 request continuously, fpu_gnt_i=1 each cycle, FIFO drained each cycle -> grants alternate 0,1,0,1 starting with core 0 after reset.
- Lock: core 1 requests with fpu_gnt_i=0 for 3 cycles while core 0 asserts mid-wait -> fpu_operands_o stays core 1's value. Grant is to core 1 when fpu_gnt_i rises. Core 0 is granted next.
- Full: MAX_OUTSTANDING=4, no responses, 5 grant attempts -> 4 grants, then fpu_req_o=0. One response -> apu_rvalid_o to the first tag, and a grant is possible the next cycle.
- Routing: grants to cores 2,0,1 (NUM_REQ=3), then responses 0xA,0xB,0xC -> rvalid on cores 2,0,1 with results A,B,C respectively.
- Simultaneous push/pop at count=2 -> count stays 2 and the response goes to the oldest tag.
- Error: fpu_rvalid_i with empty FIFO -> with CV32E40P_APU_ARB_ERR_EN, err_o=1 from the next cycle until reset. Without the macro, err_o=0. No apu_rvalid_o in either build.
